// File: rtl/zeroriscy_vector_store_unit.sv
// -----------------------------------------------------------------------------
// zeroriscy_vector_store_unit
//
// Stores one 4-lane x 32-bit vector register to data memory as four strided
// word stores, one outstanding memory transaction at a time.
//
// Sequence: IDLE -> READ (snapshot register file) -> { REQ -> WAIT } per lane
//           -> DONE (one-cycle done_o pulse) -> IDLE.
// A bus error reported with rvalid abandons the remaining lanes and sets the
// sticky err_o, which is cleared only when the next command is accepted.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   start_i         single-cycle store command (sampled in IDLE only)
//   vreg_addr_i     source vector register index
//   base_addr_i     byte address of lane 0
//   stride_i        byte distance between consecutive lanes
//   busy_o          high in every state except IDLE
//   done_o          one-cycle completion pulse (success or error)
//   err_o           sticky bus-error flag
//   vrf_raddr_o     registered register-file read address
//   vrf_rdata_i     register-file read data, lane 0 in the low word
//   data_*          core data-memory request/grant/rvalid interface
// -----------------------------------------------------------------------------
module zeroriscy_vector_store_unit #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [3:0]                  vreg_addr_i,
  input  logic [31:0]                 base_addr_i,
  input  logic [31:0]                 stride_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [3:0]                  vrf_raddr_o,
  input  logic [NUM_LANES*DATA_W-1:0] vrf_rdata_i,
  output logic                        data_req_o,
  input  logic                        data_gnt_i,
  input  logic                        data_rvalid_i,
  input  logic                        data_err_i,
  output logic [31:0]                 data_addr_o,
  output logic                        data_we_o,
  output logic [3:0]                  data_be_o,
  output logic [DATA_W-1:0]           data_wdata_o
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [LANE_W-1:0] lane_q;
  logic              accept;
  logic              advance;
  logic              in_req;

  logic [31:0]                          acc_q;
  logic [31:0]                          stride_q;
  logic [NUM_LANES-1:0][DATA_W-1:0]     lane_buf_q;

  // Command decode: a start is only honoured in IDLE; a lane advances only on
  // an error-free response that is not the last lane.
  assign accept  = (state_q == S_IDLE) && start_i;
  assign advance = (state_q == S_WAIT) && data_rvalid_i && !data_err_i &&
                   (lane_q != LAST_LANE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_READ;
      S_READ: state_d = S_REQ;
      S_REQ:  if (data_gnt_i) state_d = S_WAIT;
      S_WAIT: begin
        if (data_rvalid_i) begin
          if (data_err_i || (lane_q == LAST_LANE)) state_d = S_DONE;
          else                                     state_d = S_REQ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, lane counter, sticky error, read address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      err_o       <= 1'b0;
      vrf_raddr_o <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lane_q      <= '0;
        err_o       <= 1'b0;
        vrf_raddr_o <= vreg_addr_i;
      end else if (advance) begin
        lane_q <= lane_q + 1'b1;
      end
      if ((state_q == S_WAIT) && data_rvalid_i && data_err_i) err_o <= 1'b1;
    end
  end

  // Datapath: address accumulator, stride and the lane snapshot taken in READ.
  // These are only observable through REQ-gated outputs, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q    <= base_addr_i;
      stride_q <= stride_i;
    end else if (advance) begin
      acc_q <= acc_q + stride_q;
    end
    if (state_q == S_READ) lane_buf_q <= vrf_rdata_i;
  end

  // Memory request outputs are decoded from the state so that an asynchronous
  // reset removes the request in the same instant.
  assign in_req       = (state_q == S_REQ);
  assign data_req_o   = in_req;
  assign data_we_o    = in_req;
  assign data_be_o    = in_req ? 4'b1111 : 4'b0000;
  assign data_addr_o  = in_req ? acc_q : 32'h0;
  assign data_wdata_o = in_req ? lane_buf_q[lane_q] : '0;

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_zeroriscy_vector_store_unit.sv
module tb_zeroriscy_vector_store_unit;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [3:0]   vreg_addr_i;
  logic [31:0]  base_addr_i;
  logic [31:0]  stride_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [3:0]   vrf_raddr_o;
  logic [127:0] vrf_rdata_i;
  logic         data_req_o;
  logic         data_gnt_i;
  logic         data_rvalid_i;
  logic         data_err_i;
  logic [31:0]  data_addr_o;
  logic         data_we_o;
  logic [3:0]   data_be_o;
  logic [31:0]  data_wdata_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] vrf [16];
  int           checks;
  int           errors;

  // Memory responder configuration and state
  int err_lane;
  int stall_lane;
  int stall_cnt;
  int grant_cnt;
  bit rsp_due;
  bit rsp_err;
  bit force_rvalid;

  zeroriscy_vector_store_unit dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .vreg_addr_i   (vreg_addr_i),
    .base_addr_i   (base_addr_i),
    .stride_i      (stride_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .vrf_raddr_o   (vrf_raddr_o),
    .vrf_rdata_i   (vrf_rdata_i),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_err_i    (data_err_i),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o)
  );

  assign vrf_rdata_i = vrf[vrf_raddr_o];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Memory responder / scoreboard consumer. Acts on the falling edge: it sees
  // the request of the current cycle and drives grant for the next rising edge.
  // rvalid follows one cycle after each grant.
  initial begin
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    forever begin
      @(negedge clk);
      data_rvalid_i = 1'b0;
      data_err_i    = 1'b0;
      data_gnt_i    = 1'b0;
      if (force_rvalid) begin
        data_rvalid_i = 1'b1;
        data_err_i    = 1'b1;
      end
      if (rsp_due) begin
        data_rvalid_i = 1'b1;
        data_err_i    = rsp_err;
        rsp_due       = 1'b0;
      end
      if (data_req_o === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req addr=%h wdata=%h expected no request", data_addr_o, data_wdata_o);
        end else begin
          if (data_addr_o !== sb_q[0].addr) begin
            errors++;
            $display("FAIL store_addr lane=%0d got=%h exp=%h", grant_cnt, data_addr_o, sb_q[0].addr);
          end
          checks++;
          if (data_wdata_o !== sb_q[0].data) begin
            errors++;
            $display("FAIL store_wdata lane=%0d got=%h exp=%h", grant_cnt, data_wdata_o, sb_q[0].data);
          end
          checks++;
          if (data_be_o !== 4'b1111 || data_we_o !== 1'b1) begin
            errors++;
            $display("FAIL store_be_we lane=%0d got be=%b we=%b exp be=1111 we=1", grant_cnt, data_be_o, data_we_o);
          end
          if (stall_lane == grant_cnt && stall_cnt > 0) begin
            stall_cnt--;
          end else begin
            data_gnt_i = 1'b1;
            void'(sb_q.pop_front());
            rsp_due = 1'b1;
            rsp_err = (grant_cnt == err_lane);
            grant_cnt++;
          end
        end
      end
    end
  end

  // Issues one command and follows it to completion. Cycle 0 is the cycle in
  // which start_i is sampled; done_cyc reports the cycle of the done_o pulse.
  task automatic run_cmd(input logic [3:0] vreg, input logic [31:0] base, input logic [31:0] stride,
                         input int err_ln, input int stall_ln, input int stall_n,
                         input int wr_cyc, input int rs_cyc, input bit no_wait,
                         output int done_cyc, output logic err_c1, output logic err_done);
    int n;
    logic [127:0] v;
    err_lane   = err_ln;
    stall_lane = stall_ln;
    stall_cnt  = stall_n;
    grant_cnt  = 0;
    n = (err_ln >= 0) ? err_ln + 1 : 4;
    v = vrf[vreg];
    for (int i = 0; i < n; i++) sb_q.push_back('{addr: base + stride * 32'(i), data: v[i*32 +: 32]});
    if (!no_wait) @(negedge clk);
    vreg_addr_i = vreg;
    base_addr_i = base;
    stride_i    = stride;
    start_i     = 1'b1;
    done_cyc = -1;
    err_c1   = 1'b0;
    err_done = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_i     = 1'b0;
        base_addr_i = 32'hDEAD_BEEF;
        stride_i    = 32'h0BAD_0001;
        vreg_addr_i = ~vreg;
        err_c1      = err_o;
        checks++;
        if (busy_o !== 1'b1) begin
          errors++;
          $display("FAIL busy_cycle1 got=%b exp=1", busy_o);
        end
      end
      if (c == wr_cyc) vrf[vreg] = ~vrf[vreg];
      if (c == rs_cyc) begin
        start_i     = 1'b1;
        base_addr_i = 32'h0000_5000;
      end
      if (c == rs_cyc + 1) start_i = 1'b0;
      if (done_o === 1'b1) begin
        done_cyc = c;
        err_done = err_o;
        break;
      end
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout got=no done_o exp=done_o within 80 cycles");
    end
    checks++;
    if (grant_cnt != n) begin
      errors++;
      $display("FAIL grant_count got=%0d exp=%0d", grant_cnt, n);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL stores_missing got=%0d left exp=0", sb_q.size());
    end
    sb_q.delete();
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL after_done got done=%b busy=%b exp done=0 busy=0", done_o, busy_o);
    end
    checks++;
    if (err_o !== err_done) begin
      errors++;
      $display("FAIL err_sticky got=%b exp=%b", err_o, err_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, done_o, err_o, data_req_o, data_we_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b err=%b req=%b we=%b exp all 0", busy_o, done_o, err_o, data_req_o, data_we_o);
    end
    checks++;
    if (vrf_raddr_o !== 4'h0 || data_be_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_raddr_be got raddr=%h be=%b exp 0 0", vrf_raddr_o, data_be_o);
    end
    checks++;
    if (data_addr_o !== 32'h0 || data_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr_wdata got addr=%h wdata=%h exp 0 0", data_addr_o, data_wdata_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int dc; logic e1, ed;
    run_cmd(4'd3, 32'h0000_1000, 32'd4, -1, -1, 0, -1, -1, 1'b0, dc, e1, ed);
    checks++;
    if (dc != 10) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=10", dc); end
    checks++;
    if (ed !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", ed); end
  endtask

  task automatic test_grant_stall;
    int dc; logic e1, ed;
    run_cmd(4'd3, 32'h0000_1000, 32'd4, -1, 1, 3, -1, -1, 1'b0, dc, e1, ed);
    checks++;
    if (dc != 13) begin errors++; $display("FAIL stall_done_cycle got=%0d exp=13", dc); end
  endtask

  task automatic test_bus_error;
    int dc; logic e1, ed;
    run_cmd(4'd3, 32'h0000_1000, 32'd4, 2, -1, 0, -1, -1, 1'b0, dc, e1, ed);
    checks++;
    if (dc != 8) begin errors++; $display("FAIL buserr_done_cycle got=%0d exp=8", dc); end
    checks++;
    if (ed !== 1'b1) begin errors++; $display("FAIL buserr_err got=%b exp=1", ed); end
    run_cmd(4'd3, 32'h0000_2000, 32'd4, -1, -1, 0, -1, -1, 1'b0, dc, e1, ed);
    checks++;
    if (e1 !== 1'b0) begin errors++; $display("FAIL err_clear_on_start got=%b exp=0", e1); end
    checks++;
    if (ed !== 1'b0 || dc != 10) begin errors++; $display("FAIL after_err_cmd got err=%b done=%0d exp err=0 done=10", ed, dc); end
  endtask

  task automatic test_wrap_and_zero_stride;
    int dc; logic e1, ed;
    run_cmd(4'd5, 32'hFFFF_FFF8, 32'd8, -1, -1, 0, -1, -1, 1'b0, dc, e1, ed);
    checks++;
    if (dc != 10) begin errors++; $display("FAIL wrap_done_cycle got=%0d exp=10", dc); end
    run_cmd(4'd7, 32'h0000_2002, 32'd0, -1, -1, 0, -1, -1, 1'b0, dc, e1, ed);
    checks++;
    if (dc != 10) begin errors++; $display("FAIL zero_stride_done_cycle got=%0d exp=10", dc); end
  endtask

  task automatic test_snapshot_ignore;
    int dc; logic e1, ed;
    run_cmd(4'd3, 32'h0000_3000, 32'd16, -1, -1, 0, 3, 5, 1'b0, dc, e1, ed);
    checks++;
    if (dc != 10) begin errors++; $display("FAIL snapshot_done_cycle got=%0d exp=10", dc); end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL ignored_start_restarted got busy=%b exp=0", busy_o); end
  endtask

  task automatic test_back_to_back;
    int dc; logic e1, ed;
    run_cmd(4'd9, 32'h0000_4000, 32'd4, -1, -1, 0, -1, -1, 1'b0, dc, e1, ed);
    run_cmd(4'd10, 32'h0000_4100, 32'hFFFF_FFFC, -1, -1, 0, -1, -1, 1'b1, dc, e1, ed);
    checks++;
    if (dc != 10) begin errors++; $display("FAIL back_to_back_done_cycle got=%0d exp=10", dc); end
  endtask

  task automatic test_reset_midop;
    int dc; logic e1, ed;
    bit seen_done;
    err_lane = -1; stall_lane = -1; stall_cnt = 0; grant_cnt = 0;
    for (int i = 0; i < 4; i++) sb_q.push_back('{addr: 32'h6000 + 32'(i * 4), data: vrf[3][i*32 +: 32]});
    @(negedge clk);
    vreg_addr_i = 4'd3; base_addr_i = 32'h6000; stride_i = 32'd4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, data_req_o, data_we_o} !== 5'b0) begin
      errors++;
      $display("FAIL midop_reset_ctrl got busy=%b done=%b err=%b req=%b we=%b exp all 0", busy_o, done_o, err_o, data_req_o, data_we_o);
    end
    checks++;
    if (vrf_raddr_o !== 4'h0 || data_be_o !== 4'h0 || data_addr_o !== 32'h0 || data_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset_data got raddr=%h be=%b addr=%h wdata=%h exp all 0", vrf_raddr_o, data_be_o, data_addr_o, data_wdata_o);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_o !== 1'b0) seen_done = 1'b1;
    end
    sb_q.delete();
    rsp_due = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1 force_rvalid = 1'b1;
    @(posedge clk); #1 force_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done_o !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL midop_no_done got=done pulse exp=no done pulse"); end
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_rvalid got busy=%b err=%b exp 0 0", busy_o, err_o);
    end
    run_cmd(4'd3, 32'h0000_7000, 32'd4, -1, -1, 0, -1, -1, 1'b0, dc, e1, ed);
    checks++;
    if (dc != 10 || ed !== 1'b0) begin errors++; $display("FAIL post_reset_cmd got done=%0d err=%b exp done=10 err=0", dc, ed); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    start_i = 1'b0; vreg_addr_i = '0; base_addr_i = '0; stride_i = '0;
    err_lane = -1; stall_lane = -1; stall_cnt = 0; grant_cnt = 0;
    rsp_due = 1'b0; rsp_err = 1'b0; force_rvalid = 1'b0;
    for (int r = 0; r < 16; r++) vrf[r] = {$urandom, $urandom, $urandom, $urandom};
    vrf[3] = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h0000_0000};
    test_reset();
    test_basic();
    test_grant_stall();
    test_bus_error();
    test_wrap_and_zero_stride();
    test_snapshot_ignore();
    test_back_to_back();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
